// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   - parity_type encodings (PAR_*), stop-bit encodings (STOP_*)
//   - tx_state_t: transmit FSM state encoding
//   - parity helpers used when a frame is loaded
package uart_pkg;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // True when the frame carries a parity bit (00 and 11 both mean none).
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  // data_xor is the XOR of all data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [1:0] ptype, input logic data_xor);
    return (ptype == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: producer-side word handshake of the UART transmitter.
//   din       : word to transmit
//   din_valid : producer has a word on din
//   din_ready : transmitter FIFO has room
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
// din_ready depends only on registered FIFO state, never on din_valid.
// While din_valid is low, din is don't-care.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding words waiting for transmission.
//   clk, reset : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : remove head; ignored while empty
//   head       : current head word (valid when count != 0)
//   count      : number of words held
//   ready      : count < FIFO_DEPTH
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr;
  logic                 rd;

  assign ready = (count < CW'(FIFO_DEPTH));
  assign wr    = push && ready;
  assign rd    = pop && (count != '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; emptiness is tracked by count and pointers alone.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an input FIFO.
//   clk, reset  : clock, synchronous active-low reset
//   enable      : allows new frames to start (a running frame always completes)
//   baud_div    : clocks per bit, values below 2 act as 2; latched at frame start
//   parity_type : 00/11 none, 01 odd, 10 even; latched at frame start
//   stop_bits   : 0 one stop bit, 1 two stop bits; latched at frame start
//   tx_if       : din/din_valid/din_ready word handshake (slave side)
//   fifo_count  : words waiting in the FIFO
//   sending     : high while a frame is on the line
//   out         : serial output, idles high, driven from a flop
//   state_dbg   : current FSM state (tx_state_t encoding)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DIV_WIDTH-1:0]         baud_div,
  input  logic [1:0]                   parity_type,
  input  logic                         stop_bits,
  uart_tx_param_if.slave               tx_if,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         sending,
  output logic                         out,
  output logic [2:0]                   state_dbg
);
  localparam logic [2:0] ST_IDLE   = TX_IDLE;
  localparam logic [2:0] ST_START  = TX_START;
  localparam logic [2:0] ST_DATA   = TX_DATA;
  localparam logic [2:0] ST_PARITY = TX_PARITY;
  localparam logic [2:0] ST_STOP   = TX_STOP;

  logic [2:0]           state;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shreg;
  logic                 din_ready;
  logic                 pop;
  logic [DIV_WIDTH-1:0] per_in;
  logic [DIV_WIDTH-1:0] per_q;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [1:0]           par_q;
  logic                 stop_q;
  logic                 par_val;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 have_word;
  logic                 last_stop;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_if.din_valid),
    .din   (tx_if.din),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .ready (din_ready)
  );

  assign tx_if.din_ready = din_ready;
  assign state_dbg       = state;

  assign per_in    = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign tick      = (baud_cnt == '0);
  assign have_word = enable && (fifo_count != '0);
  assign last_stop = (bit_cnt == {3'b000, stop_q});

  // A frame starts from IDLE, or straight out of the final stop bit so that
  // back-to-back frames have no idle gap.
  assign pop = have_word &&
               ((state == ST_IDLE) || ((state == ST_STOP) && tick && last_stop));

  // baud_cnt is loaded with period-1 at each bit boundary and the boundary
  // fires when it reaches zero, giving exactly per_q clocks per bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      out      <= 1'b1;
      sending  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      per_q    <= DIV_WIDTH'(2);
      par_q    <= PAR_NONE;
      stop_q   <= STOP_ONE;
      par_val  <= 1'b0;
    end else if (pop) begin
      state    <= ST_START;
      out      <= 1'b0;
      sending  <= 1'b1;
      baud_cnt <= per_in - DIV_WIDTH'(1);
      bit_cnt  <= '0;
      shreg    <= head;
      per_q    <= per_in;
      par_q    <= parity_type;
      stop_q   <= stop_bits;
      par_val  <= parity_bit(parity_type, ^head);
    end else if (state != ST_IDLE) begin
      if (!tick) begin
        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
      end else begin
        baud_cnt <= per_q - DIV_WIDTH'(1);
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            out     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (parity_enabled(par_q)) begin
                state <= ST_PARITY;
                out   <= par_val;
              end else begin
                state <= ST_STOP;
                out   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              out     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          ST_PARITY: begin
            state   <= ST_STOP;
            out     <= 1'b1;
            bit_cnt <= '0;
          end
          ST_STOP: begin
            if (last_stop) begin
              state   <= ST_IDLE;
              out     <= 1'b1;
              sending <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            out     <= 1'b1;
            sending <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
